// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM states,
// default latencies and the op-class helpers.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith(input md_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Execute-stage MD bundle: pipeline-side requests and forwarded operands in,
// hazard-unit and result signals out.
interface md_sched_if;
  import md_pkg::*;

  logic        md_valid;
  md_op_e      md_op;
  logic        flush;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        md_class_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_valid, md_op, flush, d1, d2, md_class_D,
    input  busy, stall_md, result, hi, lo
  );

  modport slave (
    input  md_valid, md_op, flush, d1, d2, md_class_D,
    output busy, stall_md, result, hi, lo
  );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; the scheduler only delays its result
// by a fixed latency before committing it to HI/LO.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] dvs;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic               ovf;

  assign div_zero = (d2 == 32'd0);
  // Substitute a divisor of 1 so the unused quotient never goes X on a zero divide.
  assign dvs      = div_zero ? 32'd1 : d2;
  assign ovf      = (d1 == 32'h8000_0000) && (dvs == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
  assign prod_u = {32'd0, d1} * {32'd0, d2};

  always_comb begin
    q_s = ovf ? 32'sh8000_0000 : $signed(d1) / $signed(dvs);
    r_s = ovf ? 32'sd0 : $signed(d1) % $signed(dvs);
    q_u = d1 / dvs;
    r_u = d1 % dvs;
  end

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      OP_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
      OP_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
      OP_DIV:   begin hi_res = r_s;           lo_res = q_s;          end
      OP_DIVU:  begin hi_res = r_u;           lo_res = q_u;          end
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: launches one MD op at a time, holds the result in
// pending registers for a fixed latency, then commits it to HI/LO.
//   state   | meaning
//   IDLE    | free; accepts launches and MTHI/MTLO
//   RUN     | counting down; commit to HI/LO when cnt reaches 0
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic     clk,
  input logic     reset,
  md_sched_if.slave md
);

  md_state_e   state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_dz;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_res, lo_res;
  logic        div_zero;
  logic        accept;
  logic        launch;
  logic        commit;

  md_arith u_arith (
    .op      (md.md_op),
    .d1      (md.d1),
    .d2      (md.d2),
    .hi_res  (hi_res),
    .lo_res  (lo_res),
    .div_zero(div_zero)
  );

  assign accept = md.md_valid && !md.flush && (state == ST_IDLE);
  assign launch = accept && is_arith(md.md_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_nxt = ST_RUN;
          cnt_nxt   = is_div(md.md_op) ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
        end
      end
      ST_RUN: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      if (launch) begin
        pend_hi <= hi_res;
        pend_lo <= lo_res;
        pend_dz <= is_div(md.md_op) && div_zero;
      end
      // A zero-divisor op still spends its full latency but leaves HI/LO alone.
      if (commit && !pend_dz) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (accept && md.md_op == OP_MTHI) hi_q <= md.d1;
      if (accept && md.md_op == OP_MTLO) lo_q <= md.d1;
    end
  end

  assign md.busy     = (state == ST_RUN);
  assign md.stall_md = md.md_class_D && ((state == ST_RUN) || launch);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.result   = (md.md_op == OP_MFHI) ? hi_q :
                       (md.md_op == OP_MFLO) ? lo_q : 32'd0;

endmodule
